// File: rtl/hcsr04_pkg.sv
// Shared types and protocol defaults for the HC-SR04 echo emulator and the distance measurement path.
package hcsr04_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG_HI,
    BURST,
    ECHO,
    HOLDOFF
  } state_t;

  typedef logic [15:0] us_count_t;

  localparam us_count_t US_COUNT_MAX = 16'hFFFF;

  localparam int DEF_CLK_PER_US  = 50;
  localparam int DEF_US_PER_CM   = 58;
  localparam int DEF_MIN_TRIG_US = 10;
  localparam int DEF_BURST_US    = 200;
  localparam int DEF_MAX_CM      = 400;
  localparam int DEF_TIMEOUT_US  = 38000;
  localparam int DEF_HOLDOFF_US  = 10000;

  // Out-of-range distances (zero or beyond max_cm) answer with the no-object width.
  function automatic us_count_t echo_width_us(
    input logic [8:0] d,
    input int         us_per_cm,
    input int         max_cm,
    input int         timeout_us
  );
    us_count_t w;
    if ((d != 9'd0) && (int'(d) <= max_cm)) begin
      w = us_count_t'(int'(d) * us_per_cm);
    end else begin
      w = us_count_t'(timeout_us);
    end
    return w;
  endfunction

endpackage

// File: rtl/hcsr04_echo_emulator_us_tick_gen.sv
// Microsecond prescaler: counts 0..CLK_PER_US-1 and emits a one-cycle tick on the terminal count.
module us_tick_gen #(
  parameter int CLK_PER_US = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(CLK_PER_US - 1);

  logic [CW-1:0] presc_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      presc_reg <= '0;
    end else if (presc_reg == TERMINAL) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + CW'(1);
    end
  end

  assign tick = (presc_reg == TERMINAL);

endmodule

// File: rtl/hcsr04_echo_emulator.sv
// HC-SR04 responder: trigger in, echo pulse out with width proportional to distance_cm.
// Optional build macro ECHO_JITTER_EN adds 0..3 us of LFSR-driven jitter to each echo.
module hcsr04_echo_emulator
  import hcsr04_pkg::*;
#(
  parameter int CLK_PER_US  = DEF_CLK_PER_US,
  parameter int US_PER_CM   = DEF_US_PER_CM,
  parameter int MIN_TRIG_US = DEF_MIN_TRIG_US,
  parameter int BURST_US    = DEF_BURST_US,
  parameter int MAX_CM      = DEF_MAX_CM,
  parameter int TIMEOUT_US  = DEF_TIMEOUT_US,
  parameter int HOLDOFF_US  = DEF_HOLDOFF_US
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trig,
  input  logic [8:0] distance_cm,
  output logic       echo,
  output logic       busy,
  output logic       short_trig
);

  localparam int SYNC_STAGES = 2;

  state_t    state_reg, state_next;
  us_count_t us_cnt_reg;
  us_count_t width_reg;
  us_count_t jitter_us;
  logic      trig_prev_reg;
  logic      trig_s;
  logic      trig_rise, trig_fall;
  logic      tick;
  logic      state_clear;
  logic      latch;
  logic      short_pulse;
  logic [16:0] trig_us;

  // Trigger synchronizer chain; the last stage is the only copy the FSM looks at.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      logic stage_d;
      logic stage_reg;
      if (gi == 0) begin : g_in
        assign stage_d = trig;
      end else begin : g_chain
        assign stage_d = g_sync[gi-1].stage_reg;
      end
      always_ff @(posedge clk) begin
        if (reset) begin
          stage_reg <= 1'b0;
        end else begin
          stage_reg <= stage_d;
        end
      end
    end
  endgenerate

  assign trig_s = g_sync[SYNC_STAGES-1].stage_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      trig_prev_reg <= 1'b0;
    end else begin
      trig_prev_reg <= trig_s;
    end
  end

  assign trig_rise = trig_s & ~trig_prev_reg;
  assign trig_fall = ~trig_s & trig_prev_reg;

  // Every state entry restarts both the prescaler and the us counter.
  assign state_clear = (state_next != state_reg);

  us_tick_gen #(
    .CLK_PER_US(CLK_PER_US)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(state_clear),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset || state_clear) begin
      us_cnt_reg <= '0;
    end else if (tick && (us_cnt_reg != US_COUNT_MAX)) begin
      us_cnt_reg <= us_cnt_reg + 16'd1;
    end
  end

  // The fall is seen on the cycle the last prescaler tick lands, so fold it in.
  assign trig_us = {1'b0, us_cnt_reg} + {16'd0, tick};

  always_comb begin
    state_next  = state_reg;
    latch       = 1'b0;
    short_pulse = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (trig_rise) begin
          state_next = TRIG_HI;
        end
      end
      TRIG_HI: begin
        if (trig_fall) begin
          if (trig_us >= 17'(MIN_TRIG_US)) begin
            state_next = BURST;
            latch      = 1'b1;
          end else begin
            state_next  = IDLE;
            short_pulse = 1'b1;
          end
        end
      end
      BURST: begin
        if (tick && (us_cnt_reg == us_count_t'(BURST_US - 1))) begin
          state_next = ECHO;
        end
      end
      ECHO: begin
        if (tick && (us_cnt_reg == (width_reg - 16'd1))) begin
          state_next = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (tick && (us_cnt_reg == us_count_t'(HOLDOFF_US - 1))) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

`ifdef ECHO_JITTER_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  logic [15:0] lfsr_reg;

  // Fibonacci form of x^16 + x^14 + x^13 + x^11 + 1, advanced once per accepted trigger.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_reg <= LFSR_SEED;
    end else if (latch) begin
      lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    end
  end

  assign jitter_us = {14'd0, lfsr_reg[1:0]};
`else
  assign jitter_us = '0;
`endif

  // Width is frozen at the latch so later distance_cm changes cannot disturb the pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      width_reg <= '0;
    end else if (latch) begin
      width_reg <= echo_width_us(distance_cm, US_PER_CM, MAX_CM, TIMEOUT_US) + jitter_us;
    end
  end

  assign echo       = (state_reg == ECHO);
  assign busy       = (state_reg != IDLE);
  assign short_trig = short_pulse & ~reset;

endmodule

// File: tb/tb_hcsr04_echo_emulator.sv
// Directed bench for hcsr04_echo_emulator, run with shortened timing parameters to stay brief.
module tb_hcsr04_echo_emulator;

  localparam int C    = 4;     // clocks per us
  localparam int UPC  = 5;     // us per cm
  localparam int MINT = 10;
  localparam int BU   = 20;
  localparam int MAXC = 400;
  localparam int TO   = 2500;
  localparam int HO   = 100;
`ifdef ECHO_JITTER_EN
  localparam int JIT_US = 3;
`else
  localparam int JIT_US = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       trig;
  logic [8:0] distance_cm;
  logic       echo;
  logic       busy;
  logic       short_trig;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  hcsr04_echo_emulator #(
    .CLK_PER_US (C),
    .US_PER_CM  (UPC),
    .MIN_TRIG_US(MINT),
    .BURST_US   (BU),
    .MAX_CM     (MAXC),
    .TIMEOUT_US (TO),
    .HOLDOFF_US (HO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .trig       (trig),
    .distance_cm(distance_cm),
    .echo       (echo),
    .busy       (busy),
    .short_trig (short_trig)
  );

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_trig(input int us);
    trig = 1'b1;
    repeat (us * C) tick();
    trig = 1'b0;
  endtask

  task automatic wait_echo(output int n);
    n = 0;
    while (echo !== 1'b1 && n < 20000) begin
      tick();
      n++;
    end
  endtask

  task automatic measure_echo(output int n);
    n = 0;
    while (echo === 1'b1 && n < 20000) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy !== 1'b0 && n < 20000) begin
      tick();
      n++;
    end
  endtask

  task automatic run_cycle(input int d, input int t_us, output int rise_n, output int w_n,
                           output int idle_n);
    distance_cm = 9'(d);
    pulse_trig(t_us);
    wait_echo(rise_n);
    measure_echo(w_n);
    wait_idle(idle_n);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    trig = 1'b0;
    distance_cm = 9'd0;
    repeat (3) tick();
    tests_run++;
    if (echo !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_echo: got %b expected 0", echo);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    tests_run++;
    if (short_trig !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_short_trig: got %b expected 0", short_trig);
    end
    reset = 1'b0;
    repeat (2) tick();
    $display("[TB] reset: echo=%b busy=%b short_trig=%b", echo, busy, short_trig);
  endtask

  task automatic test_basic;
    int n, w, idle_n;
    distance_cm = 9'd10;
    pulse_trig(12);
    wait_echo(n);
    // First edge captures the fall, second stage exposes it, third edge enters BURST.
    tests_run++;
    if (n != BU * C + 3) begin
      tests_failed++;
      $display("FAIL basic_fall_to_echo: got %0d cycles expected %0d", n, BU * C + 3);
    end
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_busy_in_echo: got %b expected 1", busy);
    end
    distance_cm = 9'd99;
    measure_echo(w);
    tests_run++;
    if (w < 10 * UPC * C || w > (10 * UPC + JIT_US) * C) begin
      tests_failed++;
      $display("FAIL basic_width: got %0d cycles expected %0d", w, 10 * UPC * C);
    end
    wait_idle(idle_n);
    tests_run++;
    if (idle_n != HO * C) begin
      tests_failed++;
      $display("FAIL basic_holdoff: got %0d cycles expected %0d", idle_n, HO * C);
    end
    $display("[TB] basic d=10: rise=%0d width=%0d holdoff=%0d", n, w, idle_n);
  endtask

  task automatic test_short_trig;
    int cnt;
    distance_cm = 9'd10;
    pulse_trig(5);
    tick();
    tick();
    tests_run++;
    if (short_trig !== 1'b1) begin
      tests_failed++;
      $display("FAIL short_pulse: got %b expected 1", short_trig);
    end
    cnt = 0;
    repeat (BU * C + 20) begin
      tick();
      if (short_trig === 1'b1) cnt++;
      if (echo === 1'b1) cnt += 100;
    end
    tests_run++;
    if (cnt != 0) begin
      tests_failed++;
      $display("FAIL short_after: got %0d extra events expected 0", cnt);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL short_busy: got %b expected 0", busy);
    end
    $display("[TB] short trig 5us: extra_events=%0d busy=%b", cnt, busy);
  endtask

  task automatic test_min_boundary;
    int cnt, n, w, idle_n;
    distance_cm = 9'd4;
    pulse_trig(MINT - 1);
    cnt = 0;
    repeat (5) begin
      tick();
      if (short_trig === 1'b1) cnt++;
    end
    tests_run++;
    if (cnt != 1) begin
      tests_failed++;
      $display("FAIL min_minus1_short: got %0d pulses expected 1", cnt);
    end
    repeat (4) tick();
    pulse_trig(MINT);
    cnt = 0;
    repeat (5) begin
      tick();
      if (short_trig === 1'b1) cnt++;
    end
    tests_run++;
    if (cnt != 0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL min_exact_accept: got short=%0d busy=%b expected short=0 busy=1", cnt, busy);
    end
    wait_echo(n);
    measure_echo(w);
    wait_idle(idle_n);
    tests_run++;
    if (w < 4 * UPC * C || w > (4 * UPC + JIT_US) * C) begin
      tests_failed++;
      $display("FAIL min_exact_width: got %0d cycles expected %0d", w, 4 * UPC * C);
    end
    $display("[TB] min boundary: 9us rejected, 10us width=%0d", w);
  endtask

  task automatic test_no_object;
    int n, w, idle_n;
    int dists[3] = '{0, 401, 400};
    int exp_us[3] = '{TO, TO, 400 * UPC};
    for (int i = 0; i < 3; i++) begin
      run_cycle(dists[i], 12, n, w, idle_n);
      tests_run++;
      if (w < exp_us[i] * C || w > (exp_us[i] + JIT_US) * C) begin
        tests_failed++;
        $display("FAIL range_width_d%0d: got %0d cycles expected %0d", dists[i], w, exp_us[i] * C);
      end
      $display("[TB] range d=%0d: width=%0d cycles", dists[i], w);
    end
  endtask

  task automatic test_back_to_back;
    int n, w, idle_n, shorts, extra;
    distance_cm = 9'd10;
    pulse_trig(12);
    wait_echo(n);
    n = 0;
    shorts = 0;
    trig = 1'b1;
    repeat (12 * C) begin
      tick();
      n++;
      if (short_trig === 1'b1) shorts++;
    end
    trig = 1'b0;
    while (echo === 1'b1 && n < 20000) begin
      tick();
      n++;
      if (short_trig === 1'b1) shorts++;
    end
    tests_run++;
    if (n < 10 * UPC * C || n > (10 * UPC + JIT_US) * C) begin
      tests_failed++;
      $display("FAIL retrig_width: got %0d cycles expected %0d", n, 10 * UPC * C);
    end
    tests_run++;
    if (shorts != 0) begin
      tests_failed++;
      $display("FAIL retrig_short: got %0d pulses expected 0", shorts);
    end
    // Hold trig high across HOLDOFF into IDLE: nothing may start.
    trig = 1'b1;
    wait_idle(idle_n);
    extra = 0;
    repeat (BU * C + 20) begin
      tick();
      if (busy === 1'b1 || echo === 1'b1) extra++;
    end
    tests_run++;
    if (idle_n != HO * C || extra != 0) begin
      tests_failed++;
      $display("FAIL held_trig: got holdoff=%0d extra=%0d expected %0d and 0", idle_n, extra, HO * C);
    end
    trig = 1'b0;
    repeat (4) tick();
    run_cycle(7, 12, n, w, idle_n);
    tests_run++;
    if (w < 7 * UPC * C || w > (7 * UPC + JIT_US) * C) begin
      tests_failed++;
      $display("FAIL after_held_width: got %0d cycles expected %0d", w, 7 * UPC * C);
    end
    $display("[TB] back to back: first width ok, next d=7 width=%0d", w);
  endtask

  task automatic test_reset_mid_echo;
    int n, w, idle_n;
    distance_cm = 9'd30;
    pulse_trig(12);
    wait_echo(n);
    repeat (100 * C) tick();
    tests_run++;
    if (echo !== 1'b1) begin
      tests_failed++;
      $display("FAIL midecho_still_high: got %b expected 1", echo);
    end
    reset = 1'b1;
    tick();
    tests_run++;
    if (echo !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL midecho_reset: got echo=%b busy=%b expected 0 0", echo, busy);
    end
    reset = 1'b0;
    tick();
    run_cycle(5, 12, n, w, idle_n);
    tests_run++;
    if (n != BU * C + 3) begin
      tests_failed++;
      $display("FAIL post_reset_rise: got %0d cycles expected %0d", n, BU * C + 3);
    end
    tests_run++;
    if (w < 5 * UPC * C || w > (5 * UPC + JIT_US) * C) begin
      tests_failed++;
      $display("FAIL post_reset_width: got %0d cycles expected %0d", w, 5 * UPC * C);
    end
    $display("[TB] reset mid echo: post-reset rise=%0d width=%0d", n, w);
  endtask

  task automatic test_loopback;
    int n, w, idle_n, cm;
    int dists[3] = '{1, 57, 400};
    for (int i = 0; i < 3; i++) begin
      run_cycle(dists[i], 15, n, w, idle_n);
      cm = w / (C * UPC);
      tests_run++;
      if (cm != dists[i]) begin
        tests_failed++;
        $display("FAIL loopback_d%0d: got %0d cm expected %0d", dists[i], cm, dists[i]);
      end
      $display("[TB] loopback d=%0d: measured %0d cm", dists[i], cm);
    end
  endtask

  initial begin
    reset = 1'b1;
    trig = 1'b0;
    distance_cm = 9'd0;
    test_reset();
    test_basic();
    test_short_trig();
    test_min_boundary();
    test_no_object();
    test_back_to_back();
    test_reset_mid_echo();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
